truth_table_checker: RTL

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Compares the observed response y of a 3-input unit under check against a
// golden 8-entry truth table. A run starts with a single-cycle start pulse,
// which latches the golden table. Samples {a,b,c}/y are then accepted while the
// block is busy. A run ends when all eight input combinations have been seen,
// or when the run-cycle timeout expires. Results hold until the next start.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   begin a run (ignored while a run is in progress)
//   expected[7:0]   in   golden table indexed by {a,b,c}, latched on start
//   in_valid        in   a stimulus/response sample is presented
//   a, b, c         in   stimulus applied to the unit under check
//   y               in   observed response of the unit under check
//   in_ready        out  a sample is accepted this cycle (state RUN)
//   busy            out  state RUN
//   done            out  state DONE, results valid
//   pass            out  no mismatches and full coverage (valid with done)
//   err_count[]     out  saturating mismatch count, ERR_W bits
//   coverage[7:0]   out  bit i set once combination i has been accepted
//   first_err_idx   out  {a,b,c} of the first mismatch of the run
//   first_err_valid out  first_err_idx holds a valid value
// -----------------------------------------------------------------------------
module truth_table_checker #(
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       expected,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic [2:0]       first_err_idx,
  output logic             first_err_valid
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       exp_r;
  logic [TW-1:0]    tmo_r;

  logic             accept_s;
  logic [2:0]       idx_s;
  logic             miss_s;
  logic             tmo_hit_s;
  logic [7:0]       cov_s;
  logic [ERR_W-1:0] err_s;
  logic [2:0]       fe_idx_s;
  logic             fe_valid_s;

  // Status outputs decode directly from the state register.
  assign in_ready = (state_r == ST_RUN);
  assign busy     = (state_r == ST_RUN);
  assign done     = (state_r == ST_DONE);

  // Result values as they will stand after this edge, including the sample
  // being accepted now; both the result registers and the end-of-run decision
  // use these, so the final sample is always part of the verdict.
  always_comb begin
    accept_s   = in_valid && (state_r == ST_RUN);
    idx_s      = {a, b, c};
    miss_s     = accept_s && (y != exp_r[idx_s]);
    tmo_hit_s  = (tmo_r == TMO_LAST);
    cov_s      = coverage;
    err_s      = err_count;
    fe_idx_s   = first_err_idx;
    fe_valid_s = first_err_valid;
    if (accept_s) begin
      cov_s[idx_s] = 1'b1;
    end else begin
      cov_s = coverage;
    end
    if (miss_s && (err_count != ERR_MAX)) begin
      err_s = err_count + ERR_ONE;
    end else begin
      err_s = err_count;
    end
    if (miss_s && !first_err_valid) begin
      fe_idx_s   = idx_s;
      fe_valid_s = 1'b1;
    end else begin
      fe_idx_s   = first_err_idx;
      fe_valid_s = first_err_valid;
    end
  end

  // Next-state logic: a run ends on full coverage or on the last timeout cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if ((cov_s == 8'hFF) || tmo_hit_s) state_s = ST_DONE;
        else                               state_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Result, golden-table and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r           <= 8'h00;
      tmo_r           <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      coverage        <= 8'h00;
      first_err_idx   <= 3'd0;
      first_err_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            exp_r           <= expected;
            tmo_r           <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            coverage        <= 8'h00;
            first_err_idx   <= 3'd0;
            first_err_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          coverage        <= cov_s;
          err_count       <= err_s;
          first_err_idx   <= fe_idx_s;
          first_err_valid <= fe_valid_s;
          if (!tmo_hit_s) begin
            tmo_r <= tmo_r + TW'(1);
          end
          if (state_s == ST_DONE) begin
            pass <= (err_s == '0) && (cov_s == 8'hFF);
          end
        end
        default: begin
          pass <= 1'b0;
        end
      endcase
    end
  end

endmodule
